decrypt_out_buffer: RTL and testbench
=====================================

# decrypt_out_buffer

Output character buffer on the system-clock side, directly downstream of the decryption output mux. It accepts the decrypted 8-bit character stream (`data_i`/`valid_i`), stores it in a 16-entry FIFO, and presents it to the consumer through a valid/ready handshake. It also tracks message boundaries using the end-of-message character: it reports the length of each completed message with a one-cycle `msg_done` pulse, and flags dropped characters with a sticky `overflow`.

## Interface
- `DATA_WIDTH`, 8: character width.
- `DEPTH`, 16: FIFO entries; must be a power of two.
- `PTR_W`, 4: log2(DEPTH).
- `EOM_CHAR`, 8'hFA: end-of-message character, never stored.
- `clk_sys`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `data_i`  in  DATA_WIDTH  decrypted character from the mux.
- `valid_i`  in  1  `data_i` is valid this cycle; no backpressure exists upstream.
- `data_o`  out  DATA_WIDTH  head-of-FIFO character.
- `valid_o`  out  1  `data_o` is valid (FIFO not empty).
- `ready_i`  in  1  consumer accepts `data_o` this cycle.
- `full`  out  1  FIFO holds DEPTH entries.
- `empty`  out  1  FIFO holds 0 entries.
- `msg_done`  out  1  one-cycle pulse: a message terminator was accepted.
- `msg_len`  out  8  stored-character count of the last completed message.
- `overflow`  out  1  sticky: at least one character was dropped.
- `clr_ovf`  in  1  clears `overflow`.

## Operation
- Storage:
  - Register array `mem[DEPTH]`.
  - Pointers `wr_ptr` and `rd_ptr`, each PTR_W bits, wrapping modulo DEPTH.
  - Occupancy `count`, 0..DEPTH (PTR_W+1 bits).
- Read:
  - `rd_en = valid_o & ready_i`.
  - `valid_o = ~empty`.
  - `data_o = empty ? 0 : mem[rd_ptr]`; combinational from registered state.
- Write:
  - A character is a write candidate when `valid_i & (data_i != EOM_CHAR)`.
  - `wr_en = candidate & (~full | rd_en)`, so a write into a full FIFO succeeds if a read happens the same cycle.
  - A candidate with `full & ~rd_en` is dropped and sets `overflow`.
- `count` update:
  - `+1` on `wr_en` only.
  - `-1` on `rd_en` only.
  - Unchanged when both or neither occur.
- Status flags: `full = (count == DEPTH)`, `empty = (count == 0)`.
- Message FSM, two states:
  - IDLE → RECV: on a write candidate that is stored.
  - RECV → IDLE: on `valid_i & data_i == EOM_CHAR`.
  - IDLE → IDLE: on EOM (empty message).
  - Dropped characters do not move IDLE → RECV.
- Message length counter `cur_len` (8 bits):
  - Increments on each `wr_en` and saturates at 255.
  - On EOM, in either state: `msg_len <= cur_len`, `cur_len <= 0`, `msg_done <= 1` for exactly one cycle.
  - When `wr_en` and EOM cannot coincide, because a single `data_i` is either EOM or not.
- `overflow`:
  - Set by a drop.
  - Cleared by `clr_ovf`.
  - If a drop and `clr_ovf` occur in the same cycle, set wins.
  - Does not affect FIFO contents or pointers.
- `ready_i` while empty has no effect.

## Timing
- Reset (asynchronous assert, synchronous release) puts every output at its reset value:
  - `valid_o=0`, `data_o=0`, `full=0`, `empty=1`, `msg_done=0`, `msg_len=0`, `overflow=0`.
  - FSM in IDLE; pointers, `count` and `cur_len` = 0.
- Reset mid-message: all buffered data and `cur_len` are discarded, and no `msg_done` is issued.
- Write latency:
  - A character sampled at edge N is on `data_o` with `valid_o=1` after edge N when the FIFO was empty.
  - This gives 1-cycle fall-through; there is no combinational path from `data_i` to `data_o`.
- Read: on an edge with `rd_en`, `rd_ptr` advances and the next entry (or 0/`valid_o=0`) appears after that edge.
- Throughput: one write and one read per cycle sustained.
- `msg_done` and the new `msg_len` become visible after the edge that samples EOM. `msg_len` holds until the next EOM.
- `msg_done` may assert while the message's characters are still in the FIFO; it does not wait for drain.
- Back-to-back EOMs produce back-to-back `msg_done` pulses, the second with `msg_len=0`.
- `overflow` is visible after the edge of the drop and clears after the edge sampling `clr_ovf`.

## Test plan
- Reset then idle: `empty=1`, `valid_o=0`, `data_o=0`, `msg_len=0`, all pulses low.
- Message "HI" with `ready_i=1`:
  - Stimulus: 8'h48, 8'h49, 8'hFA on consecutive cycles.
  - Response: `data_o` shows 48 then 49, each for 1 cycle; `msg_done` pulses once with `msg_len=2`; FIFO ends empty.
- Fill with `ready_i=0`:
  - Stimulus: 17 characters 8'h00..8'h10.
  - Response: `full=1` after the 16th; 8'h10 is dropped, `overflow=1`.
  - Drain 16 reads, which must return 00..0F in order.
  - Then `clr_ovf`, giving `overflow=0`.
- Full plus simultaneous read/write:
  - Stimulus: FIFO full, `ready_i=1` and `valid_i` with 8'h55 in the same cycle.
  - Response: no overflow, `count` stays 16, 8'h55 is read last.
- Empty message and saturation:
  - Stimulus: EOM alone, then 300 characters with `ready_i=1` followed by EOM.
  - Response: first `msg_done` has `msg_len=0`; second has `msg_len=255`.
- Reset mid-message: 3 characters, assert `rst_n=0`, release, then send EOM → `msg_done` with `msg_len=0`, FIFO empty.

Source files
------------

// File: rtl/decrypt_out_buffer_if.sv
// rtl/decrypt_out_buffer_if.sv - character stream in / consumer handshake out for decrypt_out_buffer
interface decrypt_out_buffer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_i;
  logic                  valid_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  valid_o;
  logic                  ready_i;

  modport master (
    output data_i, valid_i, ready_i,
    input  data_o, valid_o
  );

  modport slave (
    input  data_i, valid_i, ready_i,
    output data_o, valid_o
  );
endinterface

// File: rtl/decrypt_out_buffer.sv
// rtl/decrypt_out_buffer.sv - 16-entry decrypted character FIFO with message length tracking and sticky overflow
module decrypt_out_buffer #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 16,
  parameter int                    PTR_W      = 4,
  parameter logic [DATA_WIDTH-1:0] EOM_CHAR   = 8'hFA
) (
  input  logic                  clk_sys,
  input  logic                  rst_n,
  decrypt_out_buffer_if.slave   bus,
  output logic                  full,
  output logic                  empty,
  output logic                  msg_done,
  output logic [7:0]            msg_len,
  output logic                  overflow,
  input  logic                  clr_ovf
);
  localparam logic [0:0]     ST_IDLE  = 1'b0;
  localparam logic [0:0]     ST_RECV  = 1'b1;
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic [0:0]            state;
  logic [7:0]            cur_len;

  logic rd_en;
  logic cand;
  logic is_eom;
  logic wr_en;
  logic drop;

  assign full        = (count == CNT_FULL);
  assign empty       = (count == '0);
  assign bus.valid_o = ~empty;
  assign bus.data_o  = empty ? '0 : mem[rd_ptr];

  always_comb begin
    rd_en  = ~empty & bus.ready_i;
    cand   = bus.valid_i & (bus.data_i != EOM_CHAR);
    is_eom = bus.valid_i & (bus.data_i == EOM_CHAR);
    // a full FIFO still accepts a write when the head leaves in the same cycle
    wr_en  = cand & (~full | rd_en);
    drop   = cand & full & ~rd_en;
  end

  always_ff @(posedge clk_sys) begin
    if (wr_en) begin
      mem[wr_ptr] <= bus.data_i;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cur_len  <= '0;
      msg_len  <= '0;
      msg_done <= 1'b0;
    end else begin
      msg_done <= is_eom;
      if (is_eom) begin
        state   <= ST_IDLE;
        msg_len <= cur_len;
        cur_len <= '0;
      end else if (wr_en) begin
        if (state == ST_IDLE) begin
          state <= ST_RECV;
        end
        if (cur_len != 8'hFF) begin
          cur_len <= cur_len + 1'b1;
        end
      end
    end
  end

  // a drop in the same cycle as clr_ovf leaves the flag set
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decrypt_out_buffer.sv
// tb/tb_decrypt_out_buffer.sv - self-checking bench for decrypt_out_buffer against a queue-based reference
module tb_decrypt_out_buffer;
  localparam logic [7:0] EOM = 8'hFA;

  logic       clk_sys = 1'b0;
  logic       rst_n   = 1'b0;
  logic       full, empty, msg_done, overflow, clr_ovf;
  logic [7:0] msg_len;

  decrypt_out_buffer_if #(.DATA_WIDTH(8)) bus ();

  decrypt_out_buffer dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .bus      (bus),
    .full     (full),
    .empty    (empty),
    .msg_done (msg_done),
    .msg_len  (msg_len),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk_sys = ~clk_sys;

  int checks   = 0;
  int failures = 0;

  // reference state
  logic [7:0] q[$];
  int         m_cur_len;
  logic [7:0] m_msg_len;
  logic       m_done;
  logic       m_ovf;

  task automatic model_reset();
    q.delete();
    m_cur_len = 0;
    m_msg_len = 8'h00;
    m_done    = 1'b0;
    m_ovf     = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic r, input logic c);
    logic rd, stored, dropped;
    rd      = (q.size() > 0) && r;
    stored  = 1'b0;
    dropped = 1'b0;
    if (v && d != EOM) begin
      if (q.size() < 16 || rd) stored = 1'b1;
      else dropped = 1'b1;
    end
    if (rd) void'(q.pop_front());
    if (stored) begin
      q.push_back(d);
      if (m_cur_len < 255) m_cur_len++;
    end
    m_done = v && d == EOM;
    if (m_done) begin
      m_msg_len = 8'(m_cur_len);
      m_cur_len = 0;
    end
    if (dropped) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic c);
    bus.valid_i = v;
    bus.data_i  = d;
    bus.ready_i = r;
    clr_ovf     = c;
    model_step(v, d, r, c);
    @(posedge clk_sys);
    #1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    clr_ovf     = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] rand_char();
    logic [7:0] c;
    c = 8'($urandom_range(0, 255));
    if (c == EOM) c = 8'h00;
    return c;
  endfunction

  task automatic test_reset();
    apply_reset();
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if ({empty, bus.valid_o, bus.data_o, msg_len, msg_done, overflow, full} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: empty=%b valid=%b data=%h len=%h done=%b ovf=%b full=%b", empty, bus.valid_o, bus.data_o, msg_len, msg_done, overflow, full);
    end
  endtask

  task automatic test_hi_message();
    cycle(1'b1, 8'h48, 1'b1, 1'b0);
    checks++;
    if (bus.valid_o !== 1'b1 || bus.data_o !== 8'h48) begin
      failures++;
      $display("FAIL hi_first: valid=%b data=%h required 1/48", bus.valid_o, bus.data_o);
    end
    cycle(1'b1, 8'h49, 1'b1, 1'b0);
    checks++;
    if (bus.valid_o !== 1'b1 || bus.data_o !== 8'h49 || msg_done !== 1'b0) begin
      failures++;
      $display("FAIL hi_second: valid=%b data=%h done=%b required 1/49/0", bus.valid_o, bus.data_o, msg_done);
    end
    cycle(1'b1, EOM, 1'b1, 1'b0);
    checks++;
    if (msg_done !== 1'b1 || msg_len !== 8'd2 || empty !== 1'b1) begin
      failures++;
      $display("FAIL hi_eom: done=%b len=%0d empty=%b required 1/2/1", msg_done, msg_len, empty);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (msg_done !== 1'b0 || msg_len !== 8'd2) begin
      failures++;
      $display("FAIL hi_pulse_width: done=%b len=%0d required 0/2", msg_done, msg_len);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    checks++;
    if (full !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL fill_full: full=%b ovf=%b required 1/0", full, overflow);
    end
    cycle(1'b1, 8'h10, 1'b0, 1'b0);
    checks++;
    if (full !== 1'b1 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL fill_drop: full=%b ovf=%b required 1/1", full, overflow);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.valid_o !== 1'b1 || bus.data_o !== 8'(i)) begin
        failures++;
        $display("FAIL drain_order[%0d]: valid=%b data=%h required 1/%h", i, bus.valid_o, bus.data_o, 8'(i));
      end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++;
    if (empty !== 1'b1 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL drain_end: empty=%b ovf=%b required 1/1", empty, overflow);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL clr_ovf: ovf=%b required 0", overflow);
    end
  endtask

  task automatic test_full_simul_rw();
    logic [7:0] vals [16];
    for (int i = 0; i < 16; i++) begin
      vals[i] = rand_char();
      cycle(1'b1, vals[i], 1'b0, 1'b0);
    end
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    checks++;
    if (overflow !== 1'b0 || full !== 1'b1) begin
      failures++;
      $display("FAIL full_rw: ovf=%b full=%b required 0/1", overflow, full);
    end
    for (int i = 1; i < 17; i++) begin
      logic [7:0] exp_d;
      exp_d = (i == 16) ? 8'h55 : vals[i];
      checks++;
      if (bus.data_o !== exp_d || bus.valid_o !== 1'b1) begin
        failures++;
        $display("FAIL full_rw_drain[%0d]: data=%h valid=%b required %h/1", i, bus.data_o, bus.valid_o, exp_d);
      end
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL full_rw_empty: empty=%b required 1", empty);
    end
  endtask

  task automatic test_empty_and_saturation();
    cycle(1'b1, EOM, 1'b1, 1'b0);
    cycle(1'b1, EOM, 1'b1, 1'b0);
    checks++;
    if (msg_done !== 1'b1 || msg_len !== 8'd0) begin
      failures++;
      $display("FAIL empty_msg: done=%b len=%0d required 1/0", msg_done, msg_len);
    end
    for (int i = 0; i < 300; i++) cycle(1'b1, rand_char(), 1'b1, 1'b0);
    cycle(1'b1, EOM, 1'b1, 1'b0);
    checks++;
    if (msg_done !== 1'b1 || msg_len !== 8'd255 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL saturate: done=%b len=%0d ovf=%b required 1/255/0", msg_done, msg_len, overflow);
    end
  endtask

  task automatic test_reset_mid_message();
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_char(), 1'b0, 1'b0);
    apply_reset();
    checks++;
    if (empty !== 1'b1 || bus.valid_o !== 1'b0 || bus.data_o !== 8'h00 || msg_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: empty=%b valid=%b data=%h done=%b required 1/0/00/0", empty, bus.valid_o, bus.data_o, msg_done);
    end
    cycle(1'b1, EOM, 1'b0, 1'b0);
    checks++;
    if (msg_done !== 1'b1 || msg_len !== 8'd0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_eom: done=%b len=%0d empty=%b required 1/0/1", msg_done, msg_len, empty);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      logic       v, r, c;
      logic [7:0] d, exp_d;
      v = ($urandom_range(0, 9) < 8);
      r = ($urandom_range(0, 9) < 4);
      c = ($urandom_range(0, 19) == 0);
      d = ($urandom_range(0, 14) == 0) ? EOM : rand_char();
      cycle(v, d, r, c);
      exp_d = (q.size() > 0) ? q[0] : 8'h00;
      checks++;
      if (bus.data_o !== exp_d || bus.valid_o !== (q.size() > 0) || full !== (q.size() == 16) ||
          empty !== (q.size() == 0) || msg_done !== m_done || msg_len !== m_msg_len || overflow !== m_ovf) begin
        failures++;
        $display("FAIL random[%0d]: data=%h/%h valid=%b full=%b empty=%b done=%b/%b len=%0d/%0d ovf=%b/%b size=%0d",
                 n, bus.data_o, exp_d, bus.valid_o, full, empty, msg_done, m_done, msg_len, m_msg_len, overflow, m_ovf, q.size());
      end
    end
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.data_i  = 8'h00;
    bus.ready_i = 1'b0;
    clr_ovf     = 1'b0;
    model_reset();
    test_reset();
    test_hi_message();
    test_fill_overflow();
    test_full_simul_rw();
    test_empty_and_saturation();
    test_reset_mid_message();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
